// File: rtl/boreal_channel_scheduler_pkg.sv
// Shared types and defaults for the channel scheduler.
package boreal_channel_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  localparam int unsigned DEF_CHANNELS       = 8;
  localparam int unsigned DEF_SAMPLE_W       = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
  localparam int unsigned DEF_FRAME_CNT_W    = 16;
  localparam int unsigned GAP_W              = 4;

  // Width of an index able to address n items (at least 1 bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boreal_chan_hold.sv
// Per-channel capture slot: hold register, full bit and overrun detect.
module boreal_chan_hold
  import boreal_channel_scheduler_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  input  logic [SAMPLE_W-1:0] data_i,
  input  logic                issue_i,
  output logic [SAMPLE_W-1:0] hold_o,
  output logic                full_o,
  output logic                overrun_o
);

  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic                full_q, full_d;

  // A fresh sample always wins; issuing empties the slot only when nothing new arrives.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (valid_i) begin
      hold_d = data_i;
      full_d = 1'b1;
    end else if (issue_i) begin
      full_d = 1'b0;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign hold_o    = hold_q;
  assign full_o    = full_q;
  // Overwriting an unissued sample loses data, unless the old one leaves this cycle.
  assign overrun_o = valid_i & full_q & ~issue_i;

endmodule

// File: rtl/boreal_channel_scheduler.sv
// Captures one sample per channel and issues each frame serially, channel 0 first.
module boreal_channel_scheduler
  import boreal_channel_scheduler_pkg::*;
#(
  parameter int unsigned CHANNELS       = DEF_CHANNELS,
  parameter int unsigned SAMPLE_W       = DEF_SAMPLE_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned FRAME_CNT_W    = DEF_FRAME_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*SAMPLE_W-1:0] in_data,
  input  logic [CHANNELS-1:0]          in_valid,
  input  logic                         enable,
  input  logic [GAP_W-1:0]             gap_cycles,
  input  logic                         clr_flags,
  output logic [SAMPLE_W-1:0]          filtered_sample,
  output logic [idx_w(CHANNELS)-1:0]   channel_sel,
  output logic                         sample_valid,
  output logic                         frame_done,
  output logic                         busy,
  output logic                         overrun_flag,
  output logic                         timeout_flag,
  output logic [FRAME_CNT_W-1:0]       frame_count
);

  localparam int unsigned CH_W = idx_w(CHANNELS);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         k_q, k_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic [SAMPLE_W-1:0]     sample_q, sample_d;
  logic [CH_W-1:0]         sel_q, sel_d;
  logic                    sv_q, sv_d;
  logic                    fd_q, fd_d;
  logic                    busy_q, busy_d;
  logic                    ovr_q, ovr_d;
  logic                    tmo_q, tmo_d;
  logic                    tmo_set;
  logic [FRAME_CNT_W-1:0]  fcnt_q, fcnt_d;

  logic [CHANNELS-1:0]     full_w;
  logic [CHANNELS-1:0]     ovr_w;
  logic [CHANNELS-1:0]     issue_w;
  logic [SAMPLE_W-1:0]     hold_w [CHANNELS];
  logic                    all_full;
  logic                    to_hit;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_hold
    boreal_chan_hold #(
      .SAMPLE_W(SAMPLE_W)
    ) u_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  (in_valid[i]),
      .data_i   (in_data[i*SAMPLE_W +: SAMPLE_W]),
      .issue_i  (issue_w[i]),
      .hold_o   (hold_w[i]),
      .full_o   (full_w[i]),
      .overrun_o(ovr_w[i])
    );
  end

  assign all_full = &full_w;
  assign to_hit   = (to_q == TO_LAST);

  // One-hot strobe telling the slot being issued to drop its full bit.
  always_comb begin
    issue_w = '0;
    if (state_q == ST_ISSUE) begin
      issue_w[k_q] = 1'b1;
    end
  end

  // Frame sequencing: next state, channel pointer, counters and issued-sample outputs.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    gap_d    = gap_q;
    to_d     = '0;
    sample_d = sample_q;
    sel_d    = sel_q;
    sv_d     = 1'b0;
    fd_d     = 1'b0;
    fcnt_d   = fcnt_q;
    tmo_set  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (all_full) begin
          state_d = ST_ISSUE;
        end else if (to_hit) begin
          state_d = ST_ISSUE;
          tmo_set = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_ISSUE: begin
        sv_d     = 1'b1;
        sel_d    = k_q;
        sample_d = hold_w[k_q];
        if (k_q == LAST_CH) begin
          fd_d    = 1'b1;
          fcnt_d  = fcnt_q + FRAME_CNT_W'(1);
          k_d     = '0;
          state_d = enable ? ST_COLLECT : ST_IDLE;
        end else begin
          k_d = k_q + CH_W'(1);
          if (gap_cycles != '0) begin
            gap_d   = gap_cycles;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          state_d = ST_ISSUE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky status: a set event in the same cycle as a clear keeps the flag high.
  always_comb begin
    ovr_d  = (ovr_q & ~clr_flags) | (|ovr_w);
    tmo_d  = (tmo_q & ~clr_flags) | tmo_set;
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      gap_q    <= '0;
      to_q     <= '0;
      sample_q <= '0;
      sel_q    <= '0;
      sv_q     <= 1'b0;
      fd_q     <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      gap_q    <= gap_d;
      to_q     <= to_d;
      sample_q <= sample_d;
      sel_q    <= sel_d;
      sv_q     <= sv_d;
      fd_q     <= fd_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      tmo_q    <= tmo_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign filtered_sample = sample_q;
  assign channel_sel     = sel_q;
  assign sample_valid    = sv_q;
  assign frame_done      = fd_q;
  assign busy            = busy_q;
  assign overrun_flag    = ovr_q;
  assign timeout_flag    = tmo_q;
  assign frame_count     = fcnt_q;

endmodule

// File: tb/tb_boreal_channel_scheduler.sv
// Randomized and directed bench for boreal_channel_scheduler against a frame-level reference.
module tb_boreal_channel_scheduler;

  localparam int unsigned CH = 8;
  localparam int unsigned SW = 16;
  localparam int unsigned TO = 64;
  localparam int unsigned FW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH*SW-1:0]  in_data = '0;
  logic [CH-1:0]     in_valid = '0;
  logic              enable = 1'b0;
  logic [3:0]        gap_cycles = '0;
  logic              clr_flags = 1'b0;
  logic [SW-1:0]     filtered_sample;
  logic [2:0]        channel_sel;
  logic              sample_valid;
  logic              frame_done;
  logic              busy;
  logic              overrun_flag;
  logic              timeout_flag;
  logic [FW-1:0]     frame_count;

  always #5 clk = ~clk;

  boreal_channel_scheduler #(
    .CHANNELS(CH),
    .SAMPLE_W(SW),
    .TIMEOUT_CYCLES(TO),
    .FRAME_CNT_W(FW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .enable         (enable),
    .gap_cycles     (gap_cycles),
    .clr_flags      (clr_flags),
    .filtered_sample(filtered_sample),
    .channel_sel    (channel_sel),
    .sample_valid   (sample_valid),
    .frame_done     (frame_done),
    .busy           (busy),
    .overrun_flag   (overrun_flag),
    .timeout_flag   (timeout_flag),
    .frame_count    (frame_count)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    int          cyc;
    int          ch;
    logic [15:0] data;
    logic        fd;
  } strobe_t;

  strobe_t     slog[$];

  // Reference state: what each channel slot holds, whether it is full, sticky flags.
  logic [SW-1:0] mhold [CH];
  bit            mfull [CH];
  bit            m_ovr, m_tmo, prev_all_full, af_now, ev_ovr, issuing, wd_on = 1'b0;
  int            exp_ch, ich, cyc = 0, last_strobe = 0;
  int unsigned   m_frames;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        mhold[i] = '0;
        mfull[i] = 1'b0;
      end
      m_ovr = 1'b0; m_tmo = 1'b0; prev_all_full = 1'b0;
      exp_ch = 0; m_frames = 0; last_strobe = cyc;
    end else begin
      af_now = 1'b1;
      for (int i = 0; i < CH; i++) af_now &= mfull[i];
      ich = exp_ch;
      ev_ovr = 1'b0;
      if (sample_valid) begin
        expect_eq("chan_order", channel_sel, exp_ch);
        expect_eq("data", filtered_sample, mhold[exp_ch]);
        expect_eq("frame_done", frame_done, exp_ch == CH - 1);
        if (exp_ch == 0) begin
          // frame start: a not-all-full collect decision means the timeout forced it
          m_tmo = prev_all_full ? (m_tmo & !clr_flags) : !clr_flags;
        end else begin
          expect_eq("spacing", cyc - last_strobe, gap_cycles + 1);
          m_tmo &= !clr_flags;
        end
        expect_eq("timeout_flag", timeout_flag, m_tmo);
        if (exp_ch != CH - 1) begin
          expect_eq("busy_mid", busy, 1);
        end else begin
          m_frames++;
          expect_eq("frame_count", frame_count, m_frames % 16);
        end
        slog.push_back('{cyc, int'(channel_sel), filtered_sample, frame_done});
        last_strobe = cyc;
        exp_ch = (exp_ch + 1) % CH;
      end else begin
        expect_eq("fd_quiet", frame_done, 0);
        m_tmo &= !clr_flags;
      end
      for (int i = 0; i < CH; i++) begin
        issuing = sample_valid && (i == ich);
        if (in_valid[i]) begin
          if (mfull[i] && !issuing) ev_ovr = 1'b1;
          mhold[i] = in_data[i*SW +: SW];
          mfull[i] = 1'b1;
        end else if (issuing) begin
          mfull[i] = 1'b0;
        end
      end
      m_ovr = (m_ovr & !clr_flags) | ev_ovr;
      expect_eq("overrun_flag", overrun_flag, m_ovr);
      if (wd_on) expect_eq("watchdog", (cyc - last_strobe) > 200, 0);
      prev_all_full = af_now;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = '0; enable = 1'b0; clr_flags = 1'b0; gap_cycles = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    slog.delete();
  endtask

  task automatic load_all(input logic [CH-1:0] mask, input logic [15:0] base);
    in_valid = mask;
    for (int i = 0; i < CH; i++) in_data[i*SW +: SW] = base * 16'(i + 1);
  endtask

  int e0;

  initial begin
    // ---- reset state ----
    do_reset();
    expect_eq("rst_sv", sample_valid, 0);
    expect_eq("rst_fd", frame_done, 0);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_data", filtered_sample, 0);
    expect_eq("rst_sel", channel_sel, 0);
    expect_eq("rst_fcnt", frame_count, 0);
    expect_eq("rst_flags", {overrun_flag, timeout_flag}, 0);

    // ---- one frame, back to back ----
    @(negedge clk); load_all('1, 16'h0100); enable = 1'b1; e0 = cyc + 1;
    @(negedge clk); in_valid = '0; enable = 1'b0;
    repeat (12) @(negedge clk);
    expect_eq("t1_count", slog.size(), 8);
    expect_eq("t1_latency", slog[0].cyc, e0 + 2);
    expect_eq("t1_last", slog[7].cyc, e0 + 9);
    for (int i = 0; i < CH; i++) begin
      expect_eq("t1_ch", slog[i].ch, i);
      expect_eq("t1_data", slog[i].data, 16'h0100 * 16'(i + 1));
    end
    expect_eq("t1_fd", slog[7].fd, 1);
    expect_eq("t1_fcnt", frame_count, 1);
    expect_eq("t1_busy", busy, 0);

    // ---- same frame with gap 3 ----
    slog.delete(); gap_cycles = 4'd3;
    @(negedge clk); load_all('1, 16'h0100); enable = 1'b1; e0 = cyc + 1;
    @(negedge clk); in_valid = '0; enable = 1'b0;
    repeat (40) @(negedge clk);
    expect_eq("t2_count", slog.size(), 8);
    expect_eq("t2_latency", slog[0].cyc, e0 + 2);
    expect_eq("t2_span", slog[7].cyc - slog[0].cyc, 28);
    expect_eq("t2_fcnt", frame_count, 2);

    // ---- timeout with ch5 never valid ----
    do_reset();
    @(negedge clk); load_all(8'hDF, 16'h0100); enable = 1'b1; e0 = cyc + 1;
    @(negedge clk); in_valid = '0; enable = 1'b0;
    repeat (80) @(negedge clk);
    expect_eq("t3_count", slog.size(), 8);
    expect_eq("t3_start", slog[0].cyc, e0 + 65);
    expect_eq("t3_ch5", slog[5].data, 0);
    expect_eq("t3_ch4", slog[4].data, 16'h0500);
    expect_eq("t3_flag", timeout_flag, 1);

    // ---- overrun on ch2 ----
    do_reset();
    @(negedge clk); in_valid = 8'h04; in_data[2*SW +: SW] = 16'h1111;
    @(negedge clk); load_all('1, 16'h0100); in_data[2*SW +: SW] = 16'h2222; enable = 1'b1;
    @(negedge clk); in_valid = '0; enable = 1'b0;
    expect_eq("t4_ovr_set", overrun_flag, 1);
    repeat (12) @(negedge clk);
    expect_eq("t4_count", slog.size(), 8);
    expect_eq("t4_ch2", slog[2].data, 16'h2222);
    clr_flags = 1'b1;
    @(negedge clk); clr_flags = 1'b0;
    expect_eq("t4_clr", overrun_flag, 0);
    in_valid = 8'h04;
    @(negedge clk); clr_flags = 1'b1;
    @(negedge clk); in_valid = '0; clr_flags = 1'b0;
    expect_eq("t4_set_wins", overrun_flag, 1);

    // ---- enable dropped after ch3 ----
    do_reset(); gap_cycles = 4'd2;
    @(negedge clk); load_all('1, 16'h0011); enable = 1'b1;
    @(negedge clk); in_valid = '0;
    for (int t = 0; t < 60 && slog.size() < 4; t++) @(negedge clk);
    expect_eq("t5_reach_ch3", slog.size() >= 4, 1);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    expect_eq("t5_count", slog.size(), 8);
    expect_eq("t5_fd", slog[7].fd, 1);
    expect_eq("t5_busy", busy, 0);
    repeat (100) @(negedge clk);
    expect_eq("t5_no_more", slog.size(), 8);
    expect_eq("t5_fcnt", frame_count, 1);

    // ---- async reset mid-issue ----
    do_reset();
    @(negedge clk); load_all('1, 16'h0A00); enable = 1'b1;
    @(negedge clk); in_valid = '0;
    for (int t = 0; t < 40 && slog.size() < 3; t++) @(negedge clk);
    expect_eq("t6_reach_ch2", slog.size() >= 3, 1);
    #1 rst_n = 1'b0;
    #1;
    expect_eq("t6_sv", sample_valid, 0);
    expect_eq("t6_data", filtered_sample, 0);
    expect_eq("t6_sel", channel_sel, 0);
    expect_eq("t6_busy", busy, 0);
    expect_eq("t6_fcnt", frame_count, 0);
    @(negedge clk); rst_n = 1'b1; enable = 1'b0; slog.delete();
    repeat (10) @(negedge clk);
    expect_eq("t6_idle_quiet", slog.size(), 0);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    expect_eq("t6_empty_quiet", slog.size(), 0);
    load_all('1, 16'h0033); e0 = cyc + 1;
    @(negedge clk); in_valid = '0; enable = 1'b0;
    repeat (12) @(negedge clk);
    expect_eq("t6_count", slog.size(), 8);
    expect_eq("t6_latency", slog[0].cyc, e0 + 2);

    // ---- randomized segments ----
    do_reset();
    for (int seg = 0; seg < 3; seg++) begin
      int unsigned pdiv;
      enable = 1'b0; in_valid = '0; clr_flags = 1'b0;
      for (int t = 0; t < 300 && busy; t++) @(negedge clk);
      expect_eq("seg_idle", busy, 0);
      pdiv = (seg == 0) ? 4 : (seg == 1) ? 60 : 8;
      gap_cycles = (seg == 0) ? 4'd0 : (seg == 1) ? 4'd5 : 4'd1;
      last_strobe = cyc; wd_on = 1'b1;
      repeat (600) begin
        @(negedge clk);
        for (int i = 0; i < CH; i++) begin
          in_valid[i] = ($urandom_range(pdiv - 1, 0) == 0);
          in_data[i*SW +: SW] = 16'($urandom);
        end
        enable = ($urandom_range(9, 0) != 0);
        clr_flags = ($urandom_range(19, 0) == 0);
      end
      wd_on = 1'b0;
    end
    enable = 1'b0; in_valid = '0; clr_flags = 1'b0;
    for (int t = 0; t < 300 && busy; t++) @(negedge clk);
    expect_eq("end_idle", busy, 0);
    expect_eq("end_fcnt", frame_count, m_frames % 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

endmodule
